// File: rtl/blockade_rom_loader_if.sv
// Download bus bundle between the MiST data_io ioctl stream and the game core.
//   ioctl_download : download window active            (data_io -> loader)
//   ioctl_index    : download target index             (data_io -> loader)
//   ioctl_wr       : single-cycle byte strobe          (data_io -> loader)
//   ioctl_addr     : byte address within the download  (data_io -> loader)
//   ioctl_dout     : byte data                         (data_io -> loader)
//   ioctl_wait     : back-pressure                     (loader -> data_io)
//   dn_addr/dn_wr/dn_data : core ROM download write bus (loader -> core)
// master = data_io side, slave = loader.
interface blockade_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [13:0] dn_addr;
  logic        dn_wr;
  logic [7:0]  dn_data;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, dn_addr, dn_wr, dn_data
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, dn_addr, dn_wr, dn_data
  );
endinterface

// File: rtl/blockade_rom_loader.sv
// Blockade ROM download sequencer.
// Paces ioctl bytes into the program ROM / graphics PROM download bus, holds
// the core in reset during and after a download, latches the game-mode
// trailer byte and reports load status, checksum and byte count.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   bus         : ioctl stream in, ioctl_wait and dn_* write bus out (slave)
//   core_reset  : holds the game core in reset
//   game_mode   : trailer byte bits [1:0]
//   load_done   : a complete load has finished
//   checksum    : mod-256 sum of forwarded bytes
//   byte_count  : forwarded byte count, saturating at 0x3FFF
//   overrun     : sticky, a strobe arrived while ioctl_wait was high
module blockade_rom_loader #(
  parameter int ROM_INDEX  = 0,
  parameter int WR_GAP     = 3,
  parameter int RESET_HOLD = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  blockade_rom_loader_if.slave    bus,
  output logic                    core_reset,
  output logic [1:0]              game_mode,
  output logic                    load_done,
  output logic [7:0]              checksum,
  output logic [13:0]             byte_count,
  output logic                    overrun
);
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, HOLD, DONE} state_t;

  localparam logic [24:0] TRAILER_ADDR = 25'h1400;

  state_t      state_reg;
  logic        sel_reg;
  logic [3:0]  gap_reg;
  logic [15:0] hold_reg;
  logic        wait_reg;
  logic [13:0] dn_addr_reg;
  logic        dn_wr_reg;
  logic [7:0]  dn_data_reg;
  logic        core_reset_reg;
  logic [1:0]  game_mode_reg;
  logic        load_done_reg;
  logic [7:0]  checksum_reg;
  logic [13:0] byte_count_reg;
  logic        overrun_reg;

  logic idx_match;
  logic sel;
  logic sel_rise;
  logic accept;

  assign idx_match = (bus.ioctl_index == 8'(ROM_INDEX));
  assign sel       = bus.ioctl_download && idx_match;
  assign sel_rise  = sel && !sel_reg;
  // Strobes are taken in LOAD even if the download flag drops in the same
  // cycle, so the last byte of a download is never lost.
  assign accept    = (state_reg == LOAD) && bus.ioctl_wr && idx_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      sel_reg        <= 1'b0;
      gap_reg        <= 4'd0;
      hold_reg       <= 16'd0;
      wait_reg       <= 1'b0;
      dn_addr_reg    <= 14'd0;
      dn_wr_reg      <= 1'b0;
      dn_data_reg    <= 8'd0;
      core_reset_reg <= 1'b1;
      game_mode_reg  <= 2'd0;
      load_done_reg  <= 1'b0;
      checksum_reg   <= 8'd0;
      byte_count_reg <= 14'd0;
      overrun_reg    <= 1'b0;
    end else begin
      sel_reg   <= sel;
      dn_wr_reg <= 1'b0;

      // wait_reg mirrors (gap_reg != 0) one cycle ahead so it is a flop.
      if (gap_reg != 4'd0) begin
        gap_reg  <= gap_reg - 4'd1;
        wait_reg <= (gap_reg > 4'd1);
      end

      if (accept) begin
        if (wait_reg) begin
          overrun_reg <= 1'b1;
        end else if (bus.ioctl_addr < TRAILER_ADDR) begin
          dn_addr_reg  <= bus.ioctl_addr[13:0];
          dn_data_reg  <= bus.ioctl_dout;
          dn_wr_reg    <= 1'b1;
          gap_reg      <= 4'(WR_GAP);
          wait_reg     <= 1'b1;
          checksum_reg <= checksum_reg + bus.ioctl_dout;
          if (byte_count_reg != 14'h3FFF)
            byte_count_reg <= byte_count_reg + 14'd1;
        end else if (bus.ioctl_addr == TRAILER_ADDR) begin
          game_mode_reg <= bus.ioctl_dout[1:0];
        end
      end

      // No strobe is accepted outside LOAD, so the LOAD-entry clears below
      // never collide with the accept path above.
      case (state_reg)
        LOAD: begin
          if (!sel) state_reg <= FLUSH;
        end
        FLUSH: begin
          if (gap_reg == 4'd0) begin
            state_reg <= HOLD;
            hold_reg  <= 16'(RESET_HOLD);
          end
        end
        HOLD: begin
          if (!sel_rise) begin
            hold_reg <= hold_reg - 16'd1;
            if (hold_reg == 16'd1) begin
              state_reg      <= DONE;
              core_reset_reg <= 1'b0;
              load_done_reg  <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (sel_rise && (state_reg == IDLE || state_reg == HOLD || state_reg == DONE)) begin
        state_reg      <= LOAD;
        core_reset_reg <= 1'b1;
        load_done_reg  <= 1'b0;
        checksum_reg   <= 8'd0;
        byte_count_reg <= 14'd0;
        overrun_reg    <= 1'b0;
      end
    end
  end

  assign bus.ioctl_wait = wait_reg;
  assign bus.dn_addr    = dn_addr_reg;
  assign bus.dn_wr      = dn_wr_reg;
  assign bus.dn_data    = dn_data_reg;
  assign core_reset     = core_reset_reg;
  assign game_mode      = game_mode_reg;
  assign load_done      = load_done_reg;
  assign checksum       = checksum_reg;
  assign byte_count     = byte_count_reg;
  assign overrun        = overrun_reg;
endmodule

// File: tb/tb_blockade_rom_loader.sv
// Directed bench for blockade_rom_loader: forwarded writes are pushed to a
// scoreboard queue at stimulus time and popped when dn_wr is seen.
module tb_blockade_rom_loader;
  localparam int R = 40;
  localparam int W = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_reset;
  logic [1:0]  game_mode;
  logic        load_done;
  logic [7:0]  checksum;
  logic [13:0] byte_count;
  logic        overrun;

  blockade_rom_loader_if bus();

  blockade_rom_loader #(.ROM_INDEX(0), .WR_GAP(W), .RESET_HOLD(R)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .game_mode  (game_mode),
    .load_done  (load_done),
    .checksum   (checksum),
    .byte_count (byte_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [21:0] exp_q[$];
  logic [7:0]  exp_sum;
  int          exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every dn_wr pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.dn_wr === 1'b1) begin
      pulses++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL dn_wr_unexpected observed addr %0h data %0h expected no write",
               bus.dn_addr, bus.dn_data);
      end
      if (exp_q.size() != 0) chk("dn_write", {10'd0, bus.dn_addr, bus.dn_data}, {10'd0, exp_q.pop_front()});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit fwd);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    if (fwd) begin
      exp_q.push_back({a[13:0], d});
      exp_sum = exp_sum + d;
      exp_cnt++;
    end
    @(posedge clk);
    #1;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_load();
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    exp_sum = 8'd0;
    exp_cnt = 0;
    idle(2);
    chk("load_core_reset", core_reset, 1);
    chk("load_done_clear", load_done, 0);
    chk("load_count_clear", byte_count, 0);
    chk("load_sum_clear", checksum, 0);
    chk("load_overrun_clear", overrun, 0);
  endtask

  task automatic end_load(output int n);
    bus.ioctl_download = 1'b0;
    n = 0;
    while (core_reset !== 1'b0 && n < 2 * R + 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("end_load_core_reset", core_reset, 0);
    chk("end_load_done", load_done, 1);
  endtask

  task automatic full_load();
    start_load();
    for (int a = 0; a < 5120; a++) begin
      strobe(25'(a), 8'(a), 1'b1);
      if (a == 0) begin
        chk("wait_first", bus.ioctl_wait, 1);
        chk("count_first", byte_count, 1);
        idle(W - 1);
        chk("wait_last", bus.ioctl_wait, 1);
        idle(1);
        chk("wait_release", bus.ioctl_wait, 0);
      end else begin
        idle(W);
      end
    end
    strobe(25'h1400, 8'h02, 1'b0);
    idle(W);
  endtask

  initial begin
    int n;
    int p0;

    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;
    exp_sum = 8'd0;
    exp_cnt = 0;
    idle(3);
    chk("rst_dn_addr", bus.dn_addr, 0);
    chk("rst_dn_data", bus.dn_data, 0);
    chk("rst_dn_wr", bus.dn_wr, 0);
    chk("rst_wait", bus.ioctl_wait, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_game_mode", game_mode, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    idle(50);
    chk("idle_core_reset", core_reset, 1);
    chk("idle_load_done", load_done, 0);
    chk("idle_pulses", pulses, 0);
    $display("step reset/idle done");

    full_load();
    chk("full_pulses", pulses, 5120);
    chk("full_byte_count", byte_count, exp_cnt);
    chk("full_checksum", checksum, exp_sum);
    chk("full_game_mode", game_mode, 2);
    chk("full_overrun", overrun, 0);
    chk("full_hold_addr", bus.dn_addr, 14'h13FF);
    chk("full_hold_data", bus.dn_data, 8'hFF);
    chk("full_core_reset_during", core_reset, 1);
    end_load(n);
    chk("full_release_delay", n, R + 2);
    $display("step full download done, release after %0d cycles", n);

    p0 = pulses;
    start_load();
    strobe(25'h0010, 8'hAB, 1'b1);
    strobe(25'h0011, 8'hCD, 1'b0);
    idle(W + 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_byte_count", byte_count, 1);
    chk("ovr_checksum", checksum, 8'hAB);
    chk("ovr_pulses", pulses - p0, 1);
    $display("step overrun done");

    strobe(25'h1400, 8'h03, 1'b0);
    chk("trl_wait", bus.ioctl_wait, 0);
    for (int a = 25'h1401; a <= 25'h1410; a++) begin
      strobe(25'(a), 8'(a), 1'b0);
      chk("trl_discard_wait", bus.ioctl_wait, 0);
    end
    idle(2);
    chk("trl_game_mode", game_mode, 3);
    chk("trl_byte_count", byte_count, 1);
    chk("trl_pulses", pulses - p0, 1);
    end_load(n);
    $display("step trailer done");

    p0 = pulses;
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    for (int a = 0; a < 100; a++) begin
      strobe(25'(a), 8'(a + 7), 1'b0);
      idle(W);
    end
    chk("idx1_pulses", pulses - p0, 0);
    chk("idx1_core_reset", core_reset, 0);
    chk("idx1_load_done", load_done, 1);
    chk("idx1_byte_count", byte_count, 1);
    chk("idx1_checksum", checksum, 8'hAB);
    chk("idx1_overrun", overrun, 1);
    chk("idx1_game_mode", game_mode, 3);
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    idle(2);
    $display("step foreign index done");

    start_load();
    for (int a = 0; a < 300; a++) begin
      strobe(25'(a), 8'(a * 3), 1'b1);
      idle(W);
    end
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    idle(1);
    chk("mid_rst_core_reset", core_reset, 1);
    chk("mid_rst_load_done", load_done, 0);
    chk("mid_rst_byte_count", byte_count, 0);
    chk("mid_rst_checksum", checksum, 0);
    chk("mid_rst_game_mode", game_mode, 0);
    chk("mid_rst_dn_addr", bus.dn_addr, 0);
    reset = 1'b0;
    idle(20);
    chk("mid_rst_stays_undone", load_done, 0);
    full_load();
    chk("reload_byte_count", byte_count, 14'h1400);
    end_load(n);
    chk("reload_release_delay", n, R + 2);
    $display("step reset mid-download and reload done");

    start_load();
    strobe(25'h0005, 8'h77, 1'b1);
    idle(W);
    bus.ioctl_download = 1'b0;
    idle(10);
    chk("hold_core_reset", core_reset, 1);
    chk("hold_checksum", checksum, 8'h77);
    start_load();
    end_load(n);
    $display("step restart during hold done");

    idle(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
